// File: rtl/axi_mm2s_cmd_arbiter_if.sv
// Command, completion and engine bundle shared by the two requesters,
// the command arbiter and the single MM2S engine.
interface axi_mm2s_cmd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [LEN_W-1:0]  req_len0;
    logic [LEN_W-1:0]  req_len1;
    logic [1:0]        cpl_valid;
    logic              cpl_err;
    logic              eng_start;
    logic [ADDR_W-1:0] eng_addr;
    logic [LEN_W-1:0]  eng_len;
    logic              eng_abort;
    logic              eng_busy;
    logic              eng_done;
    logic              eng_err;
    logic              grant_id;
    logic              busy;

    // arbiter side
    modport master (
        input  req_valid, req_addr0, req_addr1,
        input  req_len0, req_len1,
        input  eng_busy, eng_done, eng_err,
        output req_ready, cpl_valid, cpl_err,
        output eng_start, eng_addr, eng_len, eng_abort,
        output grant_id, busy
    );

    // requester / engine side
    modport slave (
        output req_valid, req_addr0, req_addr1,
        output req_len0, req_len1,
        output eng_busy, eng_done, eng_err,
        input  req_ready, cpl_valid, cpl_err,
        input  eng_start, eng_addr, eng_len, eng_abort,
        input  grant_id, busy
    );
endinterface

// File: rtl/axi_mm2s_cmd_arbiter.sv
// Two-requester round-robin command arbiter in front of one MM2S engine.
// One command in flight; engine hangs are cut off by a WAIT timeout.
module axi_mm2s_cmd_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axi_mm2s_cmd_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT  = '1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        CPL
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic              armed;
    logic              last_q;
    logic              gnt_q;
    logic              err_q;
    logic              err_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              pick;
    logic              accept;
    logic [ADDR_W-1:0] pick_addr;
    logic [LEN_W-1:0]  pick_len;
    logic [1:0]        ready;
    logic [1:0]        cpl;
    logic              start;
    logic              abort;
    logic              cerr;

    // round-robin choice: on a tie the requester not served last wins
    always_comb begin
        pick = bus.req_valid[1];
        if (&bus.req_valid) begin
            pick = ~last_q;
        end
    end

    assign pick_addr = pick ? bus.req_addr1 : bus.req_addr0;
    assign pick_len  = pick ? bus.req_len1 : bus.req_len0;
    assign accept    = (state == IDLE) && armed && (|bus.req_valid);

    // next state, completion status and the one-cycle pulses
    always_comb begin
        state_nx = state;
        err_nx   = err_q;
        ready    = 2'b00;
        cpl      = 2'b00;
        start    = 1'b0;
        abort    = 1'b0;
        cerr     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    ready    = pick ? 2'b10 : 2'b01;
                    err_nx   = 1'b0;
                    state_nx = (pick_len == '0) ? CPL : ISSUE;
                end
            end
            ISSUE: begin
                start    = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (bus.eng_done) begin
                    err_nx   = bus.eng_err;
                    state_nx = CPL;
                end else if (cnt == CNT_LAST) begin
                    abort    = 1'b1;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.eng_busy) begin
                    err_nx   = 1'b1;
                    state_nx = CPL;
                end
            end
            CPL: begin
                cpl      = gnt_q ? 2'b10 : 2'b01;
                cerr     = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // control state; accepts stay off until the first edge after reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            armed  <= 1'b0;
            last_q <= 1'b1;
            gnt_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            err_q <= err_nx;
            if (accept) begin
                gnt_q <= pick;
            end
            if (state == CPL) begin
                last_q <= gnt_q;
            end
        end
    end

    // command operands captured only in the accept cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q <= '0;
            len_q  <= '0;
        end else if (accept) begin
            addr_q <= pick_addr;
            len_q  <= pick_len;
        end
    end

    // WAIT-time counter, cleared while issuing, saturating
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == WAIT && cnt != CNT_SAT) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bus.req_ready = ready;
    assign bus.cpl_valid = cpl;
    assign bus.cpl_err   = cerr;
    assign bus.eng_start = start;
    assign bus.eng_abort = abort;
    assign bus.eng_addr  = addr_q;
    assign bus.eng_len   = len_q;
    assign bus.grant_id  = gnt_q;
    assign bus.busy      = (state != IDLE);
endmodule
